// File: rtl/axi_decerr_slv.sv
// Error-terminating AXI4+ATOP slave: drains writes and answers every burst
// with a fixed error response so interconnect bookkeeping stays balanced.

package axi_decerr_pkg;
    localparam int unsigned IdWidth   = 4;
    localparam int unsigned AddrWidth = 32;
    localparam int unsigned DataWidth = 64;
    localparam int unsigned UserWidth = 1;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic                 lock;
        logic [3:0]           cache;
        logic [2:0]           prot;
        logic [3:0]           qos;
        logic [3:0]           region;
        logic [5:0]           atop;
        logic [UserWidth-1:0] user;
    } aw_chan_t;

    typedef struct packed {
        logic [DataWidth-1:0]   data;
        logic [DataWidth/8-1:0] strb;
        logic                   last;
        logic [UserWidth-1:0]   user;
    } w_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [1:0]           resp;
        logic [UserWidth-1:0] user;
    } b_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic                 lock;
        logic [3:0]           cache;
        logic [2:0]           prot;
        logic [3:0]           qos;
        logic [3:0]           region;
        logic [UserWidth-1:0] user;
    } ar_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [DataWidth-1:0] data;
        logic [1:0]           resp;
        logic                 last;
        logic [UserWidth-1:0] user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic     aw_ready;
        logic     ar_ready;
        logic     w_ready;
        logic     b_valid;
        b_chan_t  b;
        logic     r_valid;
        r_chan_t  r;
    } axi_resp_t;
endpackage

// Small synchronous FIFO; a push while full is dropped, so callers gate on full_o.
module axi_decerr_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             test_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  cnt_q;
    logic             push, pop;
    logic             unused_test;

    assign unused_test = test_i;
    assign full_o      = (cnt_q == CntW'(Depth));
    assign empty_o     = (cnt_q == '0);
    assign push        = push_i & ~full_o;
    assign pop         = pop_i & ~empty_o;
    assign data_o      = mem_q[rd_ptr_q];

    // Storage needs no reset: entries are only read once counted valid.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= data_i;
    end

    // Pointers and occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
            cnt_q <= cnt_q + CntW'(push) - CntW'(pop);
        end
    end
endmodule

// State table for the R channel FSM:
//   state   | meaning
//   R_IDLE  | no burst in flight; waits for a read-tracking entry
//   R_BURST | streaming beats for the entry at the read-FIFO head
module axi_decerr_slv #(
    parameter int unsigned AxiIdWidth  = 32'd4,
    parameter bit          AtopSupport = 1'b1,
    parameter type         axi_req_t   = axi_decerr_pkg::axi_req_t,
    parameter type         axi_resp_t  = axi_decerr_pkg::axi_resp_t,
    parameter logic [1:0]  RespResp    = 2'b11,
    parameter logic [63:0] RespData    = 64'hCA11AB1E_BADCAB1E,
    parameter int unsigned MaxTrans    = 32'd4
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      test_i,
    input  axi_req_t  slv_req_i,
    output axi_resp_t slv_resp_o
);
    typedef logic [AxiIdWidth-1:0] id_t;
    typedef struct packed {
        id_t        id;
        logic [7:0] len;
    } rf_entry_t;
    typedef enum logic { R_IDLE, R_BURST } r_state_e;

    logic      atop_r, aw_ready, ar_ready, w_ready;
    logic      aw_hs, ar_hs, w_last_hs, b_hs;
    logic      wf_full, wf_empty;
    id_t       wf_head;
    logic      rf_full, rf_empty, rf_push, rf_pop;
    rf_entry_t rf_in, rf_head;
    logic      b_valid_q;
    id_t       b_id_q;
    r_state_e  state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic      r_valid, r_last;

    // Atomics need a read-tracking slot too, so AW claims the RF push ahead of AR.
    assign atop_r    = AtopSupport & slv_req_i.aw.atop[5];
    assign aw_ready  = ~wf_full & (~atop_r | ~rf_full);
    assign ar_ready  = ~rf_full & ~(slv_req_i.aw_valid & atop_r);
    assign w_ready   = ~wf_empty & ~b_valid_q;
    assign aw_hs     = slv_req_i.aw_valid & aw_ready;
    assign ar_hs     = slv_req_i.ar_valid & ar_ready;
    assign w_last_hs = slv_req_i.w_valid & w_ready & slv_req_i.w.last;
    assign b_hs      = b_valid_q & slv_req_i.b_ready;
    assign rf_push   = (aw_hs & atop_r) | ar_hs;
    assign rf_in     = (aw_hs & atop_r) ? rf_entry_t'{id: id_t'(slv_req_i.aw.id), len: slv_req_i.aw.len}
                                        : rf_entry_t'{id: id_t'(slv_req_i.ar.id), len: slv_req_i.ar.len};

    axi_decerr_fifo #(.Depth(MaxTrans), .Width(AxiIdWidth)) i_wr_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .test_i  (test_i),
        .push_i  (aw_hs),
        .data_i  (id_t'(slv_req_i.aw.id)),
        .pop_i   (w_last_hs),
        .data_o  (wf_head),
        .full_o  (wf_full),
        .empty_o (wf_empty)
    );

    axi_decerr_fifo #(.Depth(MaxTrans), .Width($bits(rf_entry_t))) i_rd_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .test_i  (test_i),
        .push_i  (rf_push),
        .data_i  (rf_in),
        .pop_i   (rf_pop),
        .data_o  (rf_head),
        .full_o  (rf_full),
        .empty_o (rf_empty)
    );

    // B response: loaded by the last W beat, held until accepted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            b_valid_q <= 1'b0;
            b_id_q    <= '0;
        end else if (w_last_hs) begin
            b_valid_q <= 1'b1;
            b_id_q    <= wf_head;
        end else if (b_hs) begin
            b_valid_q <= 1'b0;
        end
    end

    // R FSM state and beat counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= R_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // R FSM next state; the RF entry is popped only on the final beat.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_valid = 1'b0;
        r_last  = 1'b0;
        rf_pop  = 1'b0;
        unique case (state_q)
            R_IDLE: begin
                if (!rf_empty) begin
                    state_d = R_BURST;
                    cnt_d   = '0;
                end
            end
            R_BURST: begin
                r_valid = 1'b1;
                r_last  = (cnt_q == rf_head.len);
                if (slv_req_i.r_ready) begin
                    cnt_d = cnt_q + 8'd1;
                    if (r_last) begin
                        rf_pop  = 1'b1;
                        state_d = R_IDLE;
                    end
                end
            end
            default: state_d = R_IDLE;
        endcase
    end

    // Response assembly; payloads are zero whenever their valid is low.
    always_comb begin
        slv_resp_o          = '0;
        slv_resp_o.aw_ready = aw_ready;
        slv_resp_o.ar_ready = ar_ready;
        slv_resp_o.w_ready  = w_ready;
        slv_resp_o.b_valid  = b_valid_q;
        slv_resp_o.r_valid  = r_valid;
        if (b_valid_q) begin
            slv_resp_o.b.id   = b_id_q;
            slv_resp_o.b.resp = RespResp;
        end
        if (r_valid) begin
            slv_resp_o.r.id   = rf_head.id;
            slv_resp_o.r.resp = RespResp;
            slv_resp_o.r.last = r_last;
            for (int i = 0; i < $bits(slv_resp_o.r.data); i++) begin
                slv_resp_o.r.data[i] = RespData[i % 64];
            end
        end
    end
endmodule

// File: tb/tb_axi_decerr_slv.sv
module tb_axi_decerr_slv;
    import axi_decerr_pkg::*;

    localparam logic [63:0] PAT = 64'hCA11AB1E_BADCAB1E;

    logic      clk_i = 1'b0;
    logic      rst_ni;
    logic      test_i;
    axi_req_t  req;
    axi_resp_t resp;
    int        vectors = 0;
    int        miscompares = 0;
    int        hs_count;
    bit        rdy_seq  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    bit        last_seq [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [3:0] drain_ids [4] = '{4'd2, 4'd3, 4'd4, 4'd10};

    always #5 clk_i = ~clk_i;

    axi_decerr_slv #(
        .AxiIdWidth  (4),
        .AtopSupport (1'b1),
        .axi_req_t   (axi_req_t),
        .axi_resp_t  (axi_resp_t),
        .RespResp    (2'b11),
        .RespData    (PAT),
        .MaxTrans    (4)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .test_i     (test_i),
        .slv_req_i  (req),
        .slv_resp_o (resp)
    );

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        test_i = 1'b0;
        req    = '0;
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #2;
        settle();
        chk("rst_aw_ready", resp.aw_ready, 1);
        chk("rst_ar_ready", resp.ar_ready, 1);
        chk("rst_w_ready",  resp.w_ready, 0);
        chk("rst_b_valid",  resp.b_valid, 0);
        chk("rst_r_valid",  resp.r_valid, 0);
        chk("rst_b_id",     resp.b.id, 0);
        chk("rst_r_data",   resp.r.data, 0);
        rst_ni = 1'b1;
        tick();

        // single write burst
        req.b_ready  = 1'b1;
        req.r_ready  = 1'b1;
        req.aw_valid = 1'b1;
        req.aw.id    = 4'd5;
        req.aw.len   = 8'd3;
        settle();
        chk("wr_aw_ready", resp.aw_ready, 1);
        chk("wr_w_ready_pre", resp.w_ready, 0);
        tick();
        req.aw_valid = 1'b0;
        req.aw       = '0;
        req.w_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req.w.last = (i == 3);
            settle();
            chk("wr_w_ready", resp.w_ready, 1);
            chk("wr_b_early", resp.b_valid, 0);
            tick();
        end
        req.w_valid = 1'b0;
        req.w.last  = 1'b0;
        settle();
        chk("wr_b_valid", resp.b_valid, 1);
        chk("wr_b_id",    resp.b.id, 5);
        chk("wr_b_resp",  resp.b.resp, 2'b11);
        chk("wr_w_ready_b", resp.w_ready, 0);
        tick();
        settle();
        chk("wr_b_clear", resp.b_valid, 0);
        tick();
        settle();
        chk("wr_b_once", resp.b_valid, 0);

        // single read burst
        req.ar_valid = 1'b1;
        req.ar.id    = 4'd3;
        req.ar.len   = 8'd7;
        settle();
        chk("rd_ar_ready", resp.ar_ready, 1);
        tick();
        req.ar_valid = 1'b0;
        settle();
        chk("rd_lat1", resp.r_valid, 0);
        tick();
        for (int i = 0; i < 8; i++) begin
            settle();
            chk("rd_valid", resp.r_valid, 1);
            chk("rd_id",    resp.r.id, 3);
            chk("rd_data",  resp.r.data, PAT);
            chk("rd_resp",  resp.r.resp, 2'b11);
            chk("rd_last",  resp.r.last, (i == 7));
            tick();
        end
        settle();
        chk("rd_done", resp.r_valid, 0);

        // R back-pressure
        req.ar_valid = 1'b1;
        req.ar.id    = 4'd1;
        req.ar.len   = 8'd2;
        tick();
        req.ar_valid = 1'b0;
        tick();
        hs_count = 0;
        for (int i = 0; i < 5; i++) begin
            req.r_ready = rdy_seq[i];
            settle();
            chk("bp_valid", resp.r_valid, 1);
            chk("bp_id",    resp.r.id, 1);
            chk("bp_data",  resp.r.data, PAT);
            chk("bp_last",  resp.r.last, last_seq[i]);
            if (resp.r_valid && req.r_ready) hs_count++;
            tick();
        end
        req.r_ready = 1'b1;
        settle();
        chk("bp_done", resp.r_valid, 0);
        chk("bp_hs_count", hs_count, 3);

        // write FIFO full
        for (int k = 0; k < 4; k++) begin
            req.aw_valid = 1'b1;
            req.aw.id    = 4'(k + 1);
            settle();
            chk("full_aw_accept", resp.aw_ready, 1);
            tick();
        end
        req.aw.id = 4'd10;
        settle();
        chk("full_aw_refused", resp.aw_ready, 0);
        tick();
        settle();
        chk("full_aw_still", resp.aw_ready, 0);
        req.w_valid = 1'b1;
        req.w.last  = 1'b1;
        settle();
        chk("full_w_ready", resp.w_ready, 1);
        chk("full_pop_cycle", resp.aw_ready, 0);
        tick();
        settle();
        chk("full_aw_back", resp.aw_ready, 1);
        chk("full_b_valid", resp.b_valid, 1);
        chk("full_b_id",    resp.b.id, 1);
        chk("full_w_block", resp.w_ready, 0);
        tick();
        req.aw_valid = 1'b0;
        req.aw       = '0;
        settle();
        chk("full_again", resp.aw_ready, 0);
        chk("full_b_clear", resp.b_valid, 0);
        for (int k = 0; k < 4; k++) begin
            chk("drain_w_ready", resp.w_ready, 1);
            tick();
            settle();
            chk("drain_b_valid", resp.b_valid, 1);
            chk("drain_b_id",    resp.b.id, drain_ids[k]);
            tick();
            settle();
        end
        chk("drain_w_idle", resp.w_ready, 0);
        chk("drain_aw_ready", resp.aw_ready, 1);
        req.w_valid = 1'b0;
        req.w.last  = 1'b0;

        // ATOP with a competing AR
        req.aw_valid = 1'b1;
        req.aw.id    = 4'd9;
        req.aw.len   = 8'd0;
        req.aw.atop  = 6'b100000;
        req.ar_valid = 1'b1;
        req.ar.id    = 4'd6;
        req.ar.len   = 8'd1;
        settle();
        chk("atop_aw_ready", resp.aw_ready, 1);
        chk("atop_ar_block", resp.ar_ready, 0);
        tick();
        req.aw_valid = 1'b0;
        req.aw       = '0;
        req.w_valid  = 1'b1;
        req.w.last   = 1'b1;
        settle();
        chk("atop_ar_ready", resp.ar_ready, 1);
        chk("atop_w_ready",  resp.w_ready, 1);
        chk("atop_r_idle",   resp.r_valid, 0);
        tick();
        req.ar_valid = 1'b0;
        req.w_valid  = 1'b0;
        req.w.last   = 1'b0;
        settle();
        chk("atop_b_valid", resp.b_valid, 1);
        chk("atop_b_id",    resp.b.id, 9);
        chk("atop_r_valid", resp.r_valid, 1);
        chk("atop_r_id",    resp.r.id, 9);
        chk("atop_r_last",  resp.r.last, 1);
        tick();
        settle();
        chk("atop_b_clear", resp.b_valid, 0);
        chk("atop_r_gap",   resp.r_valid, 0);
        tick();
        settle();
        chk("atop_ar_r0_valid", resp.r_valid, 1);
        chk("atop_ar_r0_id",    resp.r.id, 6);
        chk("atop_ar_r0_last",  resp.r.last, 0);
        tick();
        settle();
        chk("atop_ar_r1_valid", resp.r_valid, 1);
        chk("atop_ar_r1_last",  resp.r.last, 1);
        tick();
        settle();
        chk("atop_done", resp.r_valid, 0);

        // maximum-length read burst
        req.ar_valid = 1'b1;
        req.ar.id    = 4'd7;
        req.ar.len   = 8'd255;
        settle();
        chk("long_ar_ready", resp.ar_ready, 1);
        tick();
        req.ar_valid = 1'b0;
        tick();
        for (int i = 0; i < 256; i++) begin
            settle();
            chk("long_valid_last", {resp.r_valid, resp.r.last}, {1'b1, (i == 255)});
            tick();
        end
        settle();
        chk("long_done", resp.r_valid, 0);

        // reset in the middle of a read burst
        req.ar_valid = 1'b1;
        req.ar.id    = 4'd2;
        req.ar.len   = 8'd5;
        tick();
        req.ar_valid = 1'b0;
        tick();
        settle();
        chk("mid_beat1", resp.r_valid, 1);
        tick();
        settle();
        chk("mid_beat2", resp.r_valid, 1);
        chk("mid_beat2_last", resp.r.last, 0);
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_r_valid", resp.r_valid, 0);
        chk("mid_rst_r_data",  resp.r.data, 0);
        tick();
        rst_ni = 1'b1;
        settle();
        chk("mid_aw_ready", resp.aw_ready, 1);
        chk("mid_ar_ready", resp.ar_ready, 1);
        chk("mid_r_valid",  resp.r_valid, 0);
        chk("mid_w_ready",  resp.w_ready, 0);
        tick();
        tick();
        settle();
        chk("mid_no_stale", resp.r_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
